// File: rtl/ex_alu_pkg.sv
// ex_alu_pkg: shared constants for the execute-stage ALU slice.
//   OP_*  : 4-bit Operation codes produced by the ALU control decoder.
//   ST_*  : handshake FSM state encoding used by ex_alu_stage.
package ex_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           load operands a/b and begin WIDTH iterations
//   a, b            multiplicand / multiplier (WIDTH bits)
//   done            high during the last iteration cycle
//   product         low WIDTH bits of a*b, valid while done is high
module alu_shift_add_mul import ex_alu_pkg::*; #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // Product is exposed combinationally so the caller can register it on the
  // same edge that performs the final iteration.
  assign done    = (cnt == CNT_W'(1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(WIDTH);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: registered execute stage with valid/ready on both sides.
// Optional feature macro: EX_ALU_MUL_EN (enables the iterative MUL, op 1001).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   Operation, A, B    op code and operands, qualified by InValid
//   InValid / InReady  input handshake (transfer when both high)
//   Result, Zero, Less registered result, Result==0, signed A<B for SLT
//   IllegalOp          accepted op not supported in this build
//   OutValid / OutReady output handshake
module ex_alu_stage import ex_alu_pkg::*; #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Less,
  output logic             IllegalOp,
  output logic             OutValid,
  input  logic             OutReady
);

  logic [1:0]       state;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_less;
  logic             alu_ill;
  logic             is_mul;

  always_comb begin
    alu_res  = '0;
    alu_less = 1'b0;
    alu_ill  = 1'b0;
    is_mul   = 1'b0;
    case (Operation)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_ADD: alu_res = A + B;
      OP_SUB: alu_res = A - B;
      OP_SLT: begin
        alu_less = ($signed(A) < $signed(B));
        alu_res  = {{(WIDTH-1){1'b0}}, alu_less};
      end
`ifdef EX_ALU_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // HOLD can drain and accept in the same cycle, giving one op per cycle.
  assign InReady = !reset && ((state == ST_IDLE) || ((state == ST_HOLD) && OutReady));
  assign accept  = InValid && InReady;

`ifdef EX_ALU_MUL_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      Result    <= '0;
      Zero      <= 1'b0;
      Less      <= 1'b0;
      IllegalOp <= 1'b0;
      OutValid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (is_mul) begin
              OutValid <= 1'b0;
              state    <= ST_BUSY;
            end else begin
              Result    <= alu_res;
              Zero      <= (alu_res == '0);
              Less      <= alu_less;
              IllegalOp <= alu_ill;
              OutValid  <= 1'b1;
              state     <= ST_HOLD;
            end
          end else if ((state == ST_HOLD) && OutReady) begin
            OutValid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
`ifdef EX_ALU_MUL_EN
        ST_BUSY: begin
          if (mul_done) begin
            Result    <= mul_product;
            Zero      <= (mul_product == '0);
            Less      <= 1'b0;
            IllegalOp <= 1'b0;
            OutValid  <= 1'b1;
            state     <= ST_HOLD;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed scenarios plus a randomized run against a
// transaction-level reference model of ex_alu_stage.
module tb_ex_alu_stage;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   Operation;
  logic [W-1:0] A, B, Result;
  logic         InValid, InReady, Zero, Less, IllegalOp, OutValid, OutReady;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_alu_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Operation (Operation),
    .A         (A),
    .B         (B),
    .InValid   (InValid),
    .InReady   (InReady),
    .Result    (Result),
    .Zero      (Zero),
    .Less      (Less),
    .IllegalOp (IllegalOp),
    .OutValid  (OutValid),
    .OutReady  (OutReady)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy);
    InValid   = v;
    Operation = op;
    A         = a;
    B         = b;
    OutReady  = ordy;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [W-1:0] r,
                            input logic z, input logic l, input logic ill);
    check({tag, ".valid"}, OutValid, v);
    if (v) begin
      check({tag, ".result"}, Result, r);
      check({tag, ".zero"}, Zero, z);
      check({tag, ".less"}, Less, l);
      check({tag, ".illegal"}, IllegalOp, ill);
    end
  endtask

  // Reference: what one accepted op should produce, straight from the op table.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output logic l,
                                output logic ill);
    r = '0; l = 1'b0; ill = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1000: begin l = ($signed(a) < $signed(b)); r = l ? 1 : 0; end
`ifdef EX_ALU_MUL_EN
      4'b1001: r = a * b;
`endif
      default: ill = 1'b1;
    endcase
    z = (r == 0);
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = W'($urandom_range(0, 15));
      1: v = '1;
      2: v = '0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]   ops [6];
    logic [W-1:0] all1;
    int busy_cnt, lim;
    logic ev, ez, el, ei, inv, ordy, rdy_exp;
    logic [W-1:0] er, ra, rb;
    logic [3:0] rop;

    ops  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1001};
    all1 = '1;

    // reset state
    reset = 1'b1;
    drive(1'b1, 4'b0010, 1, 1, 1'b1);
    tick; tick;
    check("rst.inready", InReady, 0);
    check("rst.valid", OutValid, 0);
    check("rst.result", Result, 0);
    check("rst.zero", Zero, 0);
    check("rst.less", Less, 0);
    check("rst.illegal", IllegalOp, 0);
    reset = 1'b0;
    drive(1'b0, 4'b0000, 0, 0, 1'b1);
    #1 check("idle.inready", InReady, 1);

    // ADD 5+7, latency 1
    drive(1'b1, 4'b0010, 5, 7, 1'b1);
    tick;
    expect_out("add", 1'b1, 12, 1'b0, 1'b0, 1'b0);

    // SUB then SLT back-to-back
    drive(1'b1, 4'b0110, 9, 9, 1'b1);
    tick;
    expect_out("sub", 1'b1, 0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'b1000, all1, 1, 1'b1);
    #1 check("b2b.inready", InReady, 1);
    tick;
    expect_out("slt", 1'b1, 1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 0, 0, 1'b1);
    tick;
    check("drain.valid", OutValid, 0);

    // AND with consumer stall; a pending OR is ignored until OutReady rises
    drive(1'b1, 4'b0000, 'hF0, 'h0F, 1'b0);
    tick;
    drive(1'b1, 4'b0001, 'hF0, 'h0F, 1'b0);
    expect_out("and", 1'b1, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_out("and.hold", 1'b1, 0, 1'b1, 1'b0, 1'b0);
      check("hold.inready", InReady, 0);
    end
    OutReady = 1'b1;
    #1 check("release.inready", InReady, 1);
    tick;
    expect_out("or", 1'b1, 'hFF, 1'b0, 1'b0, 1'b0);

    // unsupported op, then a legal op clears IllegalOp
    drive(1'b1, 4'b0101, 3, 4, 1'b1);
    tick;
    expect_out("illegal", 1'b1, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'b0010, 1, 1, 1'b1);
    tick;
    expect_out("after_ill", 1'b1, 2, 1'b0, 1'b0, 1'b0);

    // wrap-around add
    drive(1'b1, 4'b0010, all1, 1, 1'b1);
    tick;
    expect_out("wrap", 1'b1, 0, 1'b1, 1'b0, 1'b0);

`ifdef EX_ALU_MUL_EN
    drive(1'b1, 4'b1001, 6, 7, 1'b1);
    tick;
    drive(1'b0, 4'b0000, 0, 0, 1'b1);
    busy_cnt = 0;
    lim = 0;
    while (OutValid !== 1'b1 && lim < int'(W) + 8) begin
      if (InReady === 1'b0) busy_cnt++;
      tick;
      lim++;
    end
    check("mul.busy_cycles", W'(busy_cnt), W);
    expect_out("mul", 1'b1, 42, 1'b0, 1'b0, 1'b0);

    // reset in the middle of BUSY
    drive(1'b1, 4'b1001, 6, 7, 1'b1);
    tick;
    drive(1'b0, 4'b0000, 0, 0, 1'b1);
    for (int i = 0; i < 9; i++) tick;
    reset = 1'b1;
    tick;
    check("mulrst.valid", OutValid, 0);
    check("mulrst.result", Result, 0);
    reset = 1'b0;
    #1 check("mulrst.inready", InReady, 1);
    drive(1'b1, 4'b0010, 3, 4, 1'b1);
    tick;
    expect_out("mulrst.add", 1'b1, 7, 1'b0, 1'b0, 1'b0);
`else
    drive(1'b1, 4'b1001, 6, 7, 1'b1);
    tick;
    expect_out("mul_off", 1'b1, 0, 1'b1, 1'b0, 1'b1);
`endif

    drive(1'b0, 4'b0000, 0, 0, 1'b1);
    tick;
    check("pre_rnd.valid", OutValid, 0);

    // randomized traffic with random stalls on both sides
    ev = 1'b0; er = '0; ez = 1'b0; el = 1'b0; ei = 1'b0;
    for (int i = 0; i < 300; i++) begin
      inv  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      rop  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 4)];
`ifdef EX_ALU_MUL_EN
      if (rop == 4'b1001) rop = 4'b0010;
`endif
      ra = rnd_operand();
      rb = ($urandom_range(0, 4) == 0) ? ra : rnd_operand();
      drive(inv, rop, ra, rb, ordy);
      rdy_exp = !ev || ordy;
      #1 check("rnd.inready", InReady, rdy_exp);
      tick;
      if (inv && rdy_exp) begin
        model(rop, ra, rb, er, ez, el, ei);
        ev = 1'b1;
      end else if (ev && ordy) begin
        ev = 1'b0;
      end
      expect_out("rnd", ev, er, ez, el, ei);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
